// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain stage and its elastic buffer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int FIFO_RD_LATENCY = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rd_elastic_buf.sv
// Circular elastic buffer: push at tail, pop at head, occupancy count.
module rd_elastic_buf
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = 3,
  localparam int PTR_W      = ptr_w(DEPTH),
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is data path only; contents are don't-care until occupancy covers them.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && occ == OCC_W'(DEPTH)));
      assert (!(pop && occ == '0));
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: hides the registered read latency and delivers a
// framed valid/ready stream with a delivered-word counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = 3,
  parameter int BURST_LEN  = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_r,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      word_count,
  output logic                  busy
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;
  localparam int BL_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic                  inflight;
  logic                  pop;
  logic                  burst_end;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic [BL_W-1:0]       burst_cnt;
  logic [CNT_W-1:0]      word_cnt;

  // Reserve a slot for every read in flight so the returning word always fits.
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));

  assign m_valid    = !rst && (occ != '0);
  assign m_data     = rst ? '0 : head_data;
  assign burst_end  = (burst_cnt == BL_W'(BURST_LEN - 1));
  assign m_last     = m_valid && burst_end;
  assign pop        = m_valid && m_ready;
  assign busy       = !rst && ((occ != '0) || inflight);
  assign word_count = rst ? '0 : word_cnt;

  rd_elastic_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk_r),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  always_ff @(posedge clk_r) begin
    if (rst) begin
      inflight  <= 1'b0;
      burst_cnt <= '0;
      word_cnt  <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) begin
        word_cnt  <= word_cnt + CNT_W'(1);
        burst_cnt <= burst_end ? '0 : burst_cnt + BL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and stream model, per-cycle compare.
module tb_fifo_rd_stream;

  logic        clk_r = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [31:0] word_count;
  logic        busy;

  fifo_rd_stream #(
    .DATA_WIDTH (32),
    .BUF_DEPTH  (3),
    .BURST_LEN  (8),
    .CNT_W      (32)
  ) dut (
    .clk_r      (clk_r),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .word_count (word_count),
    .busy       (busy)
  );

  always #5 clk_r = ~clk_r;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO source and stage model
  logic [31:0] fifo_q[$];
  logic [31:0] mq[$];
  logic        m_infl = 1'b0;
  logic [31:0] infl_word = '0;
  int          since_rst = 0;
  logic [31:0] wcount = '0;
  logic        force_empty = 1'b0;

  // values captured at the compare point of the last step
  logic        cap_rd_en, cap_valid, cap_last, cap_busy, cap_empty, cap_pop;
  logic [31:0] cap_data, cap_wc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_seq(input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(32'(i));
  endtask

  task automatic step();
    logic        e_rd, e_v, e_l, e_b;
    logic [31:0] e_d, e_wc;
    fifo_empty = force_empty || (fifo_q.size() == 0);
    fifo_data  = m_infl ? infl_word : $urandom;
    #1;
    e_rd = !rst && !fifo_empty && ((mq.size() + int'(m_infl)) < 3);
    e_v  = !rst && (mq.size() != 0);
    e_d  = e_v ? mq[0] : 32'h0;
    e_l  = e_v && ((since_rst % 8) == 7);
    e_wc = rst ? 32'h0 : wcount;
    e_b  = !rst && ((mq.size() != 0) || m_infl);
    chk("fifo_rd_en", fifo_rd_en, e_rd);
    chk("m_valid", m_valid, e_v);
    chk("m_last", m_last, e_l);
    chk("word_count", word_count, e_wc);
    chk("busy", busy, e_b);
    if (rst || e_v) chk("m_data", m_data, e_d);
    if (prev_stall && !rst && m_valid) begin
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    cap_rd_en = fifo_rd_en; cap_valid = m_valid; cap_last = m_last;
    cap_busy = busy; cap_data = m_data; cap_wc = word_count;
    cap_empty = fifo_empty; cap_pop = e_v && m_ready;
    prev_stall = e_v && !m_ready && !rst;
    prev_data  = m_data;
    prev_last  = m_last;
    if (rst) begin
      mq.delete();
      m_infl    = 1'b0;
      since_rst = 0;
      wcount    = '0;
    end else begin
      if (cap_pop) begin
        void'(mq.pop_front());
        since_rst++;
        wcount = wcount + 32'd1;
      end
      if (m_infl) mq.push_back(infl_word);
      m_infl = e_rd;
      if (e_rd) infl_word = fifo_q.pop_front();
    end
    @(negedge clk_r);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    int pops, first, lastpop, lastcnt, reads;
    rst = 1'b1; m_ready = 1'b1; fifo_empty = 1'b0; fifo_data = '0;
    @(negedge clk_r);

    // reset with a non-empty FIFO
    fill_seq(120);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rd_en", cap_rd_en, 0);
      chk("rst_valid", cap_valid, 0);
      chk("rst_wc", cap_wc, 0);
      chk("rst_busy", cap_busy, 0);
    end

    // full-rate stream 0..119
    rst = 1'b0;
    pops = 0; first = -1; lastpop = 0; lastcnt = 0;
    for (int i = 0; i < 400 && pops < 120; i++) begin
      step();
      if (cap_valid && first < 0) first = i;
      if (cap_pop) begin
        chk("stream_data", cap_data, pops);
        if (cap_last) begin
          lastcnt++;
          chk("last_pos", pops % 8, 7);
        end
        lastpop = i;
        pops++;
      end
    end
    step();
    chk("stream_pops", pops, 120);
    chk("first_valid_lat", first, 2);
    chk("stream_gapless", lastpop - first, 119);
    chk("last_count", lastcnt, 15);
    chk("final_wc", cap_wc, 120);
    chk("drained_busy", cap_busy, 0);

    // backpressure mid-stream
    fill_seq(60);
    do_reset(1);
    pops = 0;
    for (int i = 0; i < 200 && pops < 20; i++) begin
      step();
      if (cap_pop) pops++;
    end
    m_ready = 1'b0; reads = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cap_rd_en) reads++;
      chk("bp_valid", cap_valid, 1);
      chk("bp_hold", cap_data, 20);
    end
    chk("bp_reads", reads, 1);
    chk("bp_rd_en_off", cap_rd_en, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 200 && pops < 60; i++) begin
      step();
      if (cap_pop) begin
        chk("bp_resume", cap_data, pops);
        pops++;
      end
    end
    chk("bp_pops", pops, 60);

    // fifo_empty toggling every 2 cycles
    fill_seq(40);
    do_reset(1);
    pops = 0;
    for (int i = 0; i < 400 && pops < 40; i++) begin
      force_empty = ((i / 2) % 2) == 1;
      step();
      if (cap_empty) chk("empty_rd_en", cap_rd_en, 0);
      if (cap_pop) begin
        chk("toggle_data", cap_data, pops);
        pops++;
      end
    end
    force_empty = 1'b0;
    chk("toggle_pops", pops, 40);

    // one-cycle reset after 50 delivered words
    fill_seq(100);
    do_reset(1);
    pops = 0;
    for (int i = 0; i < 200 && pops < 50; i++) begin
      step();
      if (cap_pop) pops++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_valid", cap_valid, 0);
    chk("mid_rst_wc", cap_wc, 0);
    pops = 0;
    for (int i = 0; i < 100 && pops < 8; i++) begin
      step();
      if (cap_pop) begin
        pops++;
        chk("mid_rst_last", cap_last, (pops == 8));
      end
    end
    chk("mid_rst_pops", pops, 8);

    // random backpressure and empty over 1000 words
    fifo_q.delete();
    for (int i = 0; i < 1000; i++) fifo_q.push_back($urandom);
    do_reset(2);
    pops = 0;
    for (int i = 0; i < 20000 && pops < 1000; i++) begin
      m_ready     = ($urandom_range(1, 0) == 1);
      force_empty = ($urandom_range(3, 0) == 0);
      step();
      if (cap_pop) pops++;
    end
    chk("rand_pops", pops, 1000);
    m_ready = 1'b1; force_empty = 1'b0;
    step();
    chk("rand_wc", cap_wc, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
